// File: rtl/tb_wait_pkg.sv
// Shared types and helpers for the wait-event engine: event kinds, FSM states
// and the event-match rule applied to one synchronized alias bit.
package tb_wait_pkg;

   typedef enum logic [1:0] {
      RISE = 2'd0,
      FALL = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } wait_evt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } wait_state_t;

   localparam int C_WAIT_TO_INFINITE = 0;

   function automatic logic event_met(input wait_evt_t evt, input logic prev, input logic cur);
      case (evt)
         RISE:    return !prev && cur;
         FALL:    return prev && !cur;
         HIGH:    return cur;
         default: return !cur;
      endcase
   endfunction

endpackage

// File: rtl/tb_sync_2ff.sv
// Vector-width two-flop synchronizer for asynchronous DUT output bits.
module tb_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_p0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_p0 <= '0;
         q        <= '0;
      end else begin
         stage_p0 <= d;
         q        <= stage_p0;
      end
   end

endmodule

// File: rtl/tb_wait_event.sv
// Wait-event engine: watches one synchronized alias bit for an edge or level,
// with optional timeout, and returns a one-cycle done pulse with status.
module tb_wait_event
   import tb_wait_pkg::*;
#(
   parameter int WAIT_ALIAS_NB  = 5,
   parameter int TIMEOUT_WIDTH  = 32,
   localparam int SEL_WIDTH     = $clog2(WAIT_ALIAS_NB)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_start,
   input  logic [SEL_WIDTH-1:0]     i_alias_sel,
   input  logic [1:0]               i_event_type,
   input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
   input  logic [WAIT_ALIAS_NB-1:0] i_wait,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_timeout_err,
   output logic                     o_sel_err,
   output logic [TIMEOUT_WIDTH-1:0] o_elapsed
);

   logic [WAIT_ALIAS_NB-1:0] sync_p1;
   logic [WAIT_ALIAS_NB-1:0] prev_p2;
   wait_state_t              state;
   wait_state_t              state_nxt;
   wait_evt_t                evt_q;
   logic [SEL_WIDTH-1:0]     sel_q;
   logic [TIMEOUT_WIDTH-1:0] timeout_q;
   logic [TIMEOUT_WIDTH-1:0] count;
   logic                     cur_bit;
   logic                     prev_bit;
   logic                     met;
   logic                     tout_hit;
   logic                     sel_bad;
   logic                     accept;
   logic                     tout_err_nxt;
   logic                     sel_err_nxt;

   function automatic logic [TIMEOUT_WIDTH-1:0] sat_inc(input logic [TIMEOUT_WIDTH-1:0] v);
      return (&v) ? v : v + TIMEOUT_WIDTH'(1);
   endfunction

   tb_sync_2ff #(
      .WIDTH (WAIT_ALIAS_NB)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (i_wait),
      .q     (sync_p1)
   );

   // stage 2: selected alias bit, current and previous synchronized value
   always_comb begin
      cur_bit  = 1'b0;
      prev_bit = 1'b0;
      for (int i = 0; i < WAIT_ALIAS_NB; i++) begin
         if (sel_q == SEL_WIDTH'(i)) begin
            cur_bit  = sync_p1[i];
            prev_bit = prev_p2[i];
         end
      end
   end

   assign met      = event_met(evt_q, prev_bit, cur_bit);
   // widened compare so an all-ones timeout is still reachable
   assign tout_hit = (timeout_q != TIMEOUT_WIDTH'(C_WAIT_TO_INFINITE)) &&
                     ((TIMEOUT_WIDTH+1)'(count) + (TIMEOUT_WIDTH+1)'(1) == (TIMEOUT_WIDTH+1)'(timeout_q));
   assign sel_bad  = 32'(i_alias_sel) >= 32'(WAIT_ALIAS_NB);
   assign accept   = (state == IDLE) && i_start;

   always_comb begin
      state_nxt    = state;
      tout_err_nxt = 1'b0;
      sel_err_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               if (sel_bad) begin
                  state_nxt   = DONE;
                  sel_err_nxt = 1'b1;
               end else begin
                  state_nxt = ARM;
               end
            end
         end
         ARM:  state_nxt = WAIT;
         WAIT: begin
            if (met) begin
               state_nxt = DONE;
            end else if (tout_hit) begin
               state_nxt    = DONE;
               tout_err_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // stage 3: state, registered outputs and the command context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_timeout_err <= 1'b0;
         o_sel_err     <= 1'b0;
         prev_p2       <= '0;
         sel_q         <= '0;
         evt_q         <= RISE;
         timeout_q     <= '0;
         count         <= '0;
      end else begin
         state         <= state_nxt;
         o_busy        <= (state_nxt != IDLE);
         o_done        <= (state_nxt == DONE);
         o_timeout_err <= tout_err_nxt;
         o_sel_err     <= sel_err_nxt;
         prev_p2       <= sync_p1;
         if (accept) begin
            sel_q     <= i_alias_sel;
            evt_q     <= wait_evt_t'(i_event_type);
            timeout_q <= i_timeout;
            count     <= '0;
         end else if (state == WAIT) begin
            count <= sat_inc(count);
         end
      end
   end

   assign o_elapsed = count;

endmodule

// File: tb/tb_tb_wait_event.sv
// Randomized self-checking bench for tb_wait_event against a cycle-history model.
module tb_tb_wait_event;

   localparam int NB = 5;
   localparam int TW = 32;
   localparam int SW = $clog2(NB);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [SW-1:0] i_alias_sel = '0;
   logic [1:0]    i_event_type = '0;
   logic [TW-1:0] i_timeout = '0;
   logic [NB-1:0] i_wait = '0;
   logic          o_busy;
   logic          o_done;
   logic          o_timeout_err;
   logic          o_sel_err;
   logic [TW-1:0] o_elapsed;

   int total = 0;
   int bad = 0;
   int edge_idx = 0;
   // value each synchronizer input stage captured at every clock edge
   logic [NB-1:0] hist [0:16383];

   tb_wait_event #(
      .WAIT_ALIAS_NB (NB),
      .TIMEOUT_WIDTH (TW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_alias_sel   (i_alias_sel),
      .i_event_type  (i_event_type),
      .i_timeout     (i_timeout),
      .i_wait        (i_wait),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_timeout_err (o_timeout_err),
      .o_sel_err     (o_sel_err),
      .o_elapsed     (o_elapsed)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edge_idx++;
      if (edge_idx >= 16383) begin
         $display("FAIL cycle_budget got=%0d exp<16383", edge_idx);
         $fatal(1, "cycle budget");
      end
      hist[edge_idx[13:0]] = rst_n ? i_wait : '0;
      #1;
   endtask

   function automatic logic [NB-1:0] hist_at(input int idx);
      return hist[idx[13:0]];
   endfunction

   function automatic bit evt_ok(input int typ, input bit p, input bit c);
      case (typ)
         0:       return !p && c;
         1:       return p && !c;
         2:       return c;
         default: return !c;
      endcase
   endfunction

   // lat = index of the o_done cycle, the cycle right after the start edge being 1
   task automatic run_cmd(input string name, input int sel, input int typ, input int tmo,
                          input bit rnd, input int bidx, input int off1, input bit v1,
                          input int off2, input bit v2, input bit extra, output int lat);
      int s;
      int e;
      int k;
      bit decided;
      bit exp_to;
      bit exp_se;
      int exp_el;
      bit sel_bad;
      logic [NB-1:0] hc;
      logic [NB-1:0] hp;
      sel_bad = (sel >= NB);
      decided = 1'b0;
      exp_to = 1'b0;
      exp_se = 1'b0;
      exp_el = 0;
      lat = -1;
      i_alias_sel  = SW'(sel);
      i_event_type = 2'(typ);
      i_timeout    = TW'(tmo);
      i_start      = 1'b1;
      tick();
      s = edge_idx;
      i_start = 1'b0;
      for (int n = 0; n <= 300 && !decided; n++) begin
         if (n > 0) begin
            if (rnd) i_wait = i_wait ^ NB'($urandom & $urandom);
            if (n - 1 == off1) i_wait[bidx] = v1;
            if (n - 1 == off2) i_wait[bidx] = v2;
            if (extra && n == 2) begin
               i_start     = 1'b1;
               i_alias_sel = '1;
               i_timeout   = TW'(1);
            end else begin
               i_start     = 1'b0;
               i_alias_sel = SW'(sel);
               i_timeout   = TW'(tmo);
            end
            tick();
         end
         e = edge_idx;
         if (sel_bad) begin
            if (e == s) begin
               decided = 1'b1;
               exp_se  = 1'b1;
               exp_el  = 0;
            end
         end else if (e >= s + 2) begin
            k  = e - s - 1;
            hc = hist_at(e - 2);
            hp = hist_at(e - 3);
            if (evt_ok(typ, hp[sel], hc[sel])) begin
               decided = 1'b1;
               exp_el  = k;
            end else if (tmo != 0 && k == tmo) begin
               decided = 1'b1;
               exp_to  = 1'b1;
               exp_el  = k;
            end
         end
         chk({name, ".done"}, 64'(o_done), 64'(decided));
         chk({name, ".busy"}, 64'(o_busy), 64'd1);
         if (decided) begin
            lat = e - s + 1;
            chk({name, ".timeout_err"}, 64'(o_timeout_err), 64'(exp_to));
            chk({name, ".sel_err"}, 64'(o_sel_err), 64'(exp_se));
            chk({name, ".elapsed"}, 64'(o_elapsed), 64'(exp_el));
         end
      end
      if (!decided) chk({name, ".done_in_budget"}, 64'(o_done), 64'd1);
      // a start on the DONE cycle must be dropped
      i_start = extra;
      if (extra) begin
         i_alias_sel = '1;
         i_timeout   = TW'(1);
      end
      tick();
      i_start     = 1'b0;
      i_alias_sel = SW'(sel);
      i_timeout   = TW'(tmo);
      chk({name, ".busy_after"}, 64'(o_busy), 64'd0);
      chk({name, ".done_after"}, 64'(o_done), 64'd0);
      tick();
      chk({name, ".single_done"}, 64'(o_done), 64'd0);
      chk({name, ".idle"}, 64'(o_busy), 64'd0);
      if (decided) chk({name, ".elapsed_held"}, 64'(o_elapsed), 64'(exp_el));
   endtask

   initial begin
      int lat;
      int sel;
      int typ;
      int tmo;
      for (int i = 0; i < 16384; i++) hist[i] = '0;

      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset.busy", 64'(o_busy), 64'd0);
      chk("reset.done", 64'(o_done), 64'd0);
      chk("reset.timeout_err", 64'(o_timeout_err), 64'd0);
      chk("reset.sel_err", 64'(o_sel_err), 64'd0);
      chk("reset.elapsed", 64'(o_elapsed), 64'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      i_wait = '0;
      tick();
      run_cmd("rise2", 2, 0, 100, 1'b0, 2, 10, 1'b1, -1, 1'b0, 1'b1, lat);
      chk("rise2.lat", 64'(lat), 64'd14);

      i_wait = '1;
      repeat (3) tick();
      run_cmd("fall0_to", 0, 1, 20, 1'b0, 0, -1, 1'b0, -1, 1'b0, 1'b0, lat);
      chk("fall0_to.lat", 64'(lat), 64'd22);

      i_wait = 5'b10000;
      repeat (3) tick();
      run_cmd("high4", 4, 2, 0, 1'b0, 4, -1, 1'b0, -1, 1'b0, 1'b0, lat);
      chk("high4.lat", 64'(lat), 64'd3);

      i_wait = '0;
      repeat (3) tick();
      i_wait[1] = 1'b1;
      tick();
      run_cmd("rise1_pre", 1, 0, 50, 1'b0, 1, 1, 1'b0, 3, 1'b1, 1'b0, lat);
      chk("rise1_pre.lat", 64'(lat), 64'd7);

      run_cmd("sel6", 6, 0, 10, 1'b0, 0, -1, 1'b0, -1, 1'b0, 1'b1, lat);
      chk("sel6.lat", 64'(lat), 64'd1);

      i_wait       = '0;
      i_alias_sel  = '0;
      i_event_type = 2'd2;
      i_timeout    = '0;
      i_start      = 1'b1;
      tick();
      i_start = 1'b0;
      repeat (4) tick();
      chk("rst_mid.busy_before", 64'(o_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid.busy", 64'(o_busy), 64'd0);
      chk("rst_mid.done", 64'(o_done), 64'd0);
      chk("rst_mid.timeout_err", 64'(o_timeout_err), 64'd0);
      chk("rst_mid.sel_err", 64'(o_sel_err), 64'd0);
      chk("rst_mid.elapsed", 64'(o_elapsed), 64'd0);
      tick();
      chk("rst_mid.done_held", 64'(o_done), 64'd0);
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("rst_mid.no_done", 64'(o_done), 64'd0);
         chk("rst_mid.no_busy", 64'(o_busy), 64'd0);
      end
      i_wait = '1;
      tick();
      run_cmd("low3", 3, 3, 0, 1'b0, 3, 3, 1'b0, -1, 1'b0, 1'b0, lat);

      for (int r = 0; r < 30; r++) begin
         sel = int'($urandom_range(0, 6));
         typ = int'($urandom_range(0, 3));
         tmo = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 25));
         run_cmd($sformatf("rnd%0d", r), sel, typ, tmo, 1'b1, 0, -1, 1'b0, -1, 1'b0,
                 1'($urandom_range(0, 1)), lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
